// File: rtl/vec_mag_arbiter.sv
// rtl/vec_mag_arbiter.sv - round-robin sharing of one vector-magnitude core with in-order result steering
module vec_mag_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int COORD_WIDTH  = 8,
    parameter int RES_WIDTH    = 8,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [NUM_SRC*4*COORD_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_SRC-1:0]                   s_axis_tvalid,
    output logic [NUM_SRC-1:0]                   s_axis_tready,
    output logic [4*COORD_WIDTH-1:0]             m_core_tdata,
    output logic                                 m_core_tvalid,
    output logic                                 m_core_tlast,
    input  logic                                 m_core_tready,
    input  logic [RES_WIDTH-1:0]                 s_core_tdata,
    input  logic                                 s_core_tvalid,
    output logic                                 s_core_tready,
    output logic [NUM_SRC*RES_WIDTH-1:0]         m_axis_tdata,
    output logic [NUM_SRC-1:0]                   m_axis_tvalid,
    output logic [NUM_SRC-1:0]                   m_axis_tlast,
    input  logic [NUM_SRC-1:0]                   m_axis_tready,
    output logic [$clog2(MAX_INFLIGHT):0]        inflight,
    output logic                                 err_orphan
);

    localparam int BEAT_W = 4 * COORD_WIDTH;
    localparam int SRC_W  = $clog2(NUM_SRC);
    localparam int PTR_W  = $clog2(MAX_INFLIGHT);
    localparam int CNT_W  = PTR_W + 1;

    logic                 issue_valid;
    logic [BEAT_W-1:0]    issue_data;
    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    logic                 can_load;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 grant_ok;
    logic                 grant;
    logic                 sel_found;
    logic [SRC_W-1:0]     sel_idx;
    logic [SRC_W:0]       cand;
    logic [SRC_W-1:0]     head;
    logic [SRC_W-1:0]     rr_next;
    logic                 push;
    logic                 pop;

    assign can_load   = !issue_valid || m_core_tready;
    assign fifo_full  = (count == CNT_W'(MAX_INFLIGHT));
    assign fifo_empty = (count == '0);
    // Uses the registered count, so a pop in the full cycle does not open a grant slot.
    assign grant_ok   = aresetn && can_load && !fifo_full;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(NUM_SRC)) begin
                cand = cand - (SRC_W+1)'(NUM_SRC);
            end
            if (!sel_found && s_axis_tvalid[cand[SRC_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[SRC_W-1:0];
            end
        end
    end

    assign grant   = grant_ok && sel_found;
    assign push    = grant;
    assign rr_next = (sel_idx == SRC_W'(NUM_SRC - 1)) ? '0 : sel_idx + SRC_W'(1);

    always_comb begin
        s_axis_tready = '0;
        if (grant) begin
            s_axis_tready[sel_idx] = 1'b1;
        end
    end

    assign head = tag_mem[rd_ptr];

    // Head-of-line: only the oldest tag's requester can accept, stalling everyone behind it.
    always_comb begin
        m_axis_tvalid = '0;
        s_core_tready = 1'b0;
        if (!fifo_empty) begin
            m_axis_tvalid[head] = s_core_tvalid;
            s_core_tready       = m_axis_tready[head];
        end
    end

    assign pop          = s_core_tvalid && s_core_tready;
    assign m_axis_tlast = m_axis_tvalid;
    assign m_axis_tdata = {NUM_SRC{s_core_tdata}};
    assign m_core_tdata  = issue_data;
    assign m_core_tvalid = issue_valid;
    assign m_core_tlast  = 1'b1;
    assign inflight      = count;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            issue_valid <= 1'b0;
            issue_data  <= '0;
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_orphan  <= 1'b0;
        end else begin
            if (grant) begin
                issue_valid <= 1'b1;
                issue_data  <= s_axis_tdata[sel_idx*BEAT_W +: BEAT_W];
                rr_ptr      <= rr_next;
            end else if (m_core_tready) begin
                issue_valid <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (fifo_empty && s_core_tvalid) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge aclk) begin
        if (push) begin
            tag_mem[wr_ptr] <= sel_idx;
        end
    end

endmodule

// File: doc/vec_mag_arbiter.md
# vec_mag_arbiter

Shares a single vector-magnitude pipeline core among NUM_SRC independent AXI-Stream requesters. Each request beat {x1, y1, x2, y2} is round-robin arbitrated, registered and issued to the core. The requester ID is pushed into an in-order tag FIFO, and every result returned by the core is steered back to the requester that issued it. The block sits between the per-channel front-ends and the magnitude core, and is the only master of the core.

## Interface
- NUM_SRC, 4, number of requesters (2..8).
- COORD_WIDTH, 8, coordinate width; request beat is 4*COORD_WIDTH bits.
- RES_WIDTH, 8, result width returned by the core.
- MAX_INFLIGHT, 8, tag FIFO depth; power of two, 2..32.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low; clock aclk.
- s_axis_tdata  in  NUM_SRC*4*COORD_WIDTH  request beats; slice i belongs to source i.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready; one-hot or zero.
- m_core_tdata  out  4*COORD_WIDTH  beat issued to the core.
- m_core_tvalid  out  1  issue valid.
- m_core_tlast  out  1  constant 1.
- m_core_tready  in  1  core ready.
- s_core_tdata  in  RES_WIDTH  core result.
- s_core_tvalid  in  1  core result valid.
- s_core_tready  out  1  result accept.
- m_axis_tdata  out  NUM_SRC*RES_WIDTH  per-source result; all slices carry s_core_tdata.
- m_axis_tvalid  out  NUM_SRC  per-source result valid; one-hot or zero.
- m_axis_tlast  out  NUM_SRC  per-source result last; equals m_axis_tvalid.
- m_axis_tready  in  NUM_SRC  per-source result ready.
- inflight  out  $clog2(MAX_INFLIGHT)+1  entries in the tag FIFO.
- err_orphan  out  1  sticky flag: a core result was seen with no outstanding tag.

## Operation
**Issue register.** The block holds m_core_tdata/m_core_tvalid in an output register.
- The register can accept a beat when it is empty, or when m_core_tready=1 in the same cycle.
- Once valid, the register holds its contents until m_core_tready=1.

**Arbitration.**
- Grant is possible when the issue register can accept a beat AND inflight < MAX_INFLIGHT.
- Under that condition, the block selects the first source with tvalid=1, searching from rr_ptr upward with wrap modulo NUM_SRC.
- It drives s_axis_tready=1 for that source only.
- Every other source sees s_axis_tready=0, regardless of its own tvalid.

**On an accepted request from source g:**
- load the issue register with slice g;
- push g into the tag FIFO;
- set rr_ptr to (g+1) mod NUM_SRC.
- rr_ptr does not change in cycles with no grant.

**Return path.** This path is combinational.
- With the FIFO non-empty and head tag h:
  - m_axis_tvalid[h] = s_core_tvalid;
  - s_core_tready = m_axis_tready[h].
- When s_core_tvalid and s_core_tready are both 1, the FIFO pops.
- With the FIFO empty:
  - s_core_tready=0 and all m_axis_tvalid=0;
  - if s_core_tvalid=1 in that state, err_orphan is set. It clears only on reset.

**inflight accounting.**
- A push alone increments inflight; a pop alone decrements it.
- A push and a pop in the same cycle leave it unchanged.
- Pointers wrap modulo MAX_INFLIGHT.

The core is in-order, so FIFO order equals result order.

## Timing
- **Reset values:** m_core_tvalid=0, m_core_tdata=0, s_axis_tready=0, rr_ptr=0, FIFO empty, inflight=0, err_orphan=0, s_core_tready=0, m_axis_tvalid=0.
- **Reset mid-operation:** discards the issue register and all tags. The integrator resets the core in the same cycle.
- **Request to core:** s_axis handshake in cycle n gives m_core_tvalid=1 in cycle n+1.
- **Throughput:** with m_core_tready held high and inflight below the limit, one grant per cycle.
- **Core to result:** zero cycles; m_axis_tvalid follows s_core_tvalid in the same cycle.
- **Full FIFO:**
  - A grant is blocked when inflight = MAX_INFLIGHT, even if a pop occurs in that cycle.
  - Grants resume in the cycle after inflight drops below the limit.
- **Back-pressure:** a requester with m_axis_tready=0 stalls the return path for all sources (head-of-line blocking). This is required behaviour.
- **Ready is never combinationally dependent on s_axis_tvalid of other sources,** except through arbitration selection.

## Test plan
1. **Single source:** source 2 sends 3 beats back to back with all readies=1.
   - m_core_tvalid is high in cycles 1-3 with matching data.
   - Inflight peaks at 3 when results are delayed.
   - Results appear only on m_axis_tvalid[2].
2. **Round-robin:** all 4 sources valid continuously.
   - Grant order is 0,1,2,3,0,1…
   - Each source receives exactly one grant every 4 cycles.
3. **Full FIFO:** MAX_INFLIGHT=8, core returns nothing.
   - After 8 grants, all s_axis_tready=0 and inflight=8.
   - One result accepted gives inflight=7, and a new grant follows in the next cycle.
4. **Core back-pressure:** m_core_tready=0 for 5 cycles with the register full.
   - m_core_tdata is stable and no further grants occur.
   - Issue resumes the cycle tready returns to 1.
5. **Result back-pressure:** the head tag is source 1 and m_axis_tready[1]=0.
   - s_core_tready=0 and no FIFO pop.
   - Source 3's later result waits until source 1 accepts.
6. **Orphan result, then reset:** s_core_tvalid=1 with the FIFO empty.
   - err_orphan=1 and stays set.
   - Asserting aresetn=0 for one cycle clears it along with inflight and rr_ptr.
